// File: rtl/inertial_ptch_src.sv
// inertial_ptch_src: configures the IMU over the SPI handshake, then reads the
// gyro pitch rate and Z-accel on each data-ready and integrates a pitch estimate.
// Build option: define PTCH_ACC_FUSION_EN to nudge the integrator toward the
// accel-derived pitch; undefined gives pure gyro integration.
module inertial_ptch_src #(
   parameter int unsigned INIT_WAIT_W    = 16,
   parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        INT,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic        wrt,
   output logic [15:0] cmd,
   output logic [15:0] ptch_rt,
   output logic [15:0] ptch,
   output logic        vld
);

   localparam int unsigned ACC_W = 27;

   typedef enum logic [3:0] {
      PWR_WAIT, INIT1, INIT2, INIT3, WAIT_INT,
      RD_RTL, RD_RTH, RD_AZL, RD_AZH, UPDATE
   } state_t;

   state_t                   r_state;
   logic [INIT_WAIT_W-1:0]   r_timer;
   logic                     r_int_s1, r_int_s2;
   logic                     r_wrt;
   logic [15:0]              r_cmd;
   logic [7:0]               r_rtl, r_rth, r_azl, r_azh;
   logic [15:0]              r_ptch_rt;
   logic [15:0]              r_ptch;
   logic signed [ACC_W-1:0]  r_ptch_int;
   logic                     r_vld;

   logic                     w_done_ok;
   logic [15:0]              w_rt;
   logic signed [ACC_W-1:0]  w_fusion;
   logic signed [ACC_W-1:0]  w_int_nxt;
   logic                     w_unused_hi;

   // A done is only meaningful once the start strobe has gone back low.
   assign w_done_ok   = done & ~r_wrt;
   assign w_rt        = {r_rth, r_rtl} - PTCH_RT_OFFSET;
   assign w_unused_hi = ^rd_data[15:8];

`ifdef PTCH_ACC_FUSION_EN
   logic signed [25:0] w_prod;
   logic signed [15:0] w_ptch_acc;
   logic               w_unused_acc;

   // Accel pitch: AZ scaled by 327/8192, then a fixed +/-1024 pull toward it.
   assign w_prod       = $signed({r_azh, r_azl}) * $signed(10'sd327);
   assign w_ptch_acc   = {{3{w_prod[25]}}, w_prod[25:13]};
   assign w_unused_acc = ^w_prod[12:0];
   assign w_fusion     = ($signed(w_ptch_acc) > $signed(r_ptch)) ?
                         ACC_W'(1024) : -ACC_W'(1024);
`else
   logic w_unused_az;

   // AZ is still read so the SPI sequence is unchanged, but it is not used.
   assign w_unused_az = ^{r_azh, r_azl};
   assign w_fusion    = '0;
`endif

   assign w_int_nxt = r_ptch_int - {{(ACC_W-16){w_rt[15]}}, w_rt} + w_fusion;

   assign wrt     = r_wrt;
   assign cmd     = r_cmd;
   assign ptch_rt = r_ptch_rt;
   assign ptch    = r_ptch;
   assign vld     = r_vld;

   // Sequencer: power-up wait, IMU init, then one four-read burst per data-ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= PWR_WAIT;
         r_timer    <= '0;
         r_int_s1   <= 1'b0;
         r_int_s2   <= 1'b0;
         r_wrt      <= 1'b0;
         r_cmd      <= '0;
         r_rtl      <= '0;
         r_rth      <= '0;
         r_azl      <= '0;
         r_azh      <= '0;
         r_ptch_rt  <= '0;
         r_ptch     <= '0;
         r_ptch_int <= '0;
         r_vld      <= 1'b0;
      end else begin
         r_int_s1 <= INT;
         r_int_s2 <= r_int_s1;
         r_wrt    <= 1'b0;
         r_vld    <= 1'b0;
         case (r_state)
            PWR_WAIT: begin
               r_timer <= r_timer + INIT_WAIT_W'(1);
               if (&r_timer) begin
                  r_state <= INIT1;
                  r_wrt   <= 1'b1;
                  r_cmd   <= 16'h0D02;
               end
            end
            INIT1: if (w_done_ok) begin
               r_state <= INIT2;
               r_wrt   <= 1'b1;
               r_cmd   <= 16'h1160;
            end
            INIT2: if (w_done_ok) begin
               r_state <= INIT3;
               r_wrt   <= 1'b1;
               r_cmd   <= 16'h1060;
            end
            INIT3: if (w_done_ok) begin
               r_state <= WAIT_INT;
            end
            WAIT_INT: if (r_int_s2) begin
               r_state <= RD_RTL;
               r_wrt   <= 1'b1;
               r_cmd   <= 16'hA200;
            end
            RD_RTL: if (w_done_ok) begin
               r_rtl   <= rd_data[7:0];
               r_state <= RD_RTH;
               r_wrt   <= 1'b1;
               r_cmd   <= 16'hA300;
            end
            RD_RTH: if (w_done_ok) begin
               r_rth   <= rd_data[7:0];
               r_state <= RD_AZL;
               r_wrt   <= 1'b1;
               r_cmd   <= 16'hAC00;
            end
            RD_AZL: if (w_done_ok) begin
               r_azl   <= rd_data[7:0];
               r_state <= RD_AZH;
               r_wrt   <= 1'b1;
               r_cmd   <= 16'hAD00;
            end
            RD_AZH: if (w_done_ok) begin
               r_azh   <= rd_data[7:0];
               r_state <= UPDATE;
            end
            UPDATE: begin
               r_ptch_rt  <= w_rt;
               r_ptch_int <= w_int_nxt;
               r_ptch     <= w_int_nxt[26:11];
               r_vld      <= 1'b1;
               r_state    <= WAIT_INT;
            end
            default: r_state <= PWR_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_inertial_ptch_src.sv
// Directed bench for inertial_ptch_src with a small SPI-master responder.
module tb_inertial_ptch_src;

   localparam int unsigned W         = 6;
   localparam int          WAIT_CLKS = 1 << W;

`ifdef PTCH_ACC_FUSION_EN
   localparam logic [15:0] EXP_A_PTCH = 16'hFFFF;
   localparam logic [15:0] EXP_B_PTCH = 16'hFFFD;
   localparam bit          FUSION     = 1'b1;
`else
   localparam logic [15:0] EXP_A_PTCH = 16'h0000;
   localparam logic [15:0] EXP_B_PTCH = 16'hFFFE;
   localparam bit          FUSION     = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        INT;
   logic        done;
   logic [15:0] rd_data;
   logic        wrt;
   logic [15:0] cmd;
   logic [15:0] ptch_rt;
   logic [15:0] ptch;
   logic        vld;

   int n_cmp  = 0;
   int n_fail = 0;

   inertial_ptch_src #(.INIT_WAIT_W(W), .PTCH_RT_OFFSET(16'h0050)) dut (
      .clk(clk), .rst(rst), .INT(INT), .done(done), .rd_data(rd_data),
      .wrt(wrt), .cmd(cmd), .ptch_rt(ptch_rt), .ptch(ptch), .vld(vld)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycles until wrt is seen (0 if already high), -1 on timeout.
   task automatic wait_wrt(input int budget, output int n);
      bit found;
      n     = 0;
      found = (wrt === 1'b1);
      while (!found && n < budget) begin
         tick();
         n++;
         found = (wrt === 1'b1);
      end
      if (!found) n = -1;
   endtask

   // One SPI transaction; done returned 3 cycles after wrt.
   task automatic do_txn(input string tag, input logic [15:0] exp_cmd, input logic [7:0] data);
      int n;
      wait_wrt(200, n);
      check({tag, " wrt seen"}, 16'(n >= 0), 16'd1);
      check({tag, " cmd"}, cmd, exp_cmd);
      tick();
      check({tag, " wrt one cycle"}, 16'(wrt), 16'd0);
      tick();
      check({tag, " cmd held"}, cmd, exp_cmd);
      done    = 1'b1;
      rd_data = {8'hEE, data};
      tick();
      done    = 1'b0;
      rd_data = 16'h0000;
   endtask

   task automatic do_init(input string tag);
      do_txn({tag, " INIT1"}, 16'h0D02, 8'h00);
      do_txn({tag, " INIT2"}, 16'h1160, 8'h00);
      do_txn({tag, " INIT3"}, 16'h1060, 8'h00);
   endtask

   task automatic release_and_time(input string tag);
      int n;
      rst = 1'b0;
      wait_wrt(WAIT_CLKS + 20, n);
      check({tag, " pwr wait clks"}, 16'(n), 16'(WAIT_CLKS));
   endtask

   task automatic do_read(input string tag, input logic [7:0] rtl, input logic [7:0] rth,
                          input logic [7:0] azl, input logic [7:0] azh,
                          input logic [15:0] exp_rt, input logic [15:0] exp_ptch);
      int n;
      INT = 1'b1;
      wait_wrt(20, n);
      INT = 1'b0;
      do_txn({tag, " RTL"}, 16'hA200, rtl);
      do_txn({tag, " RTH"}, 16'hA300, rth);
      do_txn({tag, " AZL"}, 16'hAC00, azl);
      do_txn({tag, " AZH"}, 16'hAD00, azh);
      tick();
      check({tag, " vld"}, 16'(vld), 16'd1);
      check({tag, " ptch_rt"}, ptch_rt, exp_rt);
      check({tag, " ptch"}, ptch, exp_ptch);
      tick();
      check({tag, " vld drop"}, 16'(vld), 16'd0);
      check({tag, " ptch hold"}, ptch, exp_ptch);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " wrt"}, 16'(wrt), 16'd0);
      check({tag, " cmd"}, cmd, 16'h0000);
      check({tag, " ptch"}, ptch, 16'h0000);
      check({tag, " ptch_rt"}, ptch_rt, 16'h0000);
      check({tag, " vld"}, 16'(vld), 16'd0);
   endtask

   initial begin
      int n;
      int cnt;
      rst     = 1'b1;
      INT     = 1'b0;
      done    = 1'b0;
      rd_data = 16'h0000;
      repeat (3) tick();
      check_zero("reset");

      // Power-up wait, init sequence, then quiet while INT is low.
      release_and_time("boot");
      do_init("boot");
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (wrt === 1'b1) cnt++;
      end
      check("idle no wrt", 16'(cnt), 16'd0);

      // Rate equal to the offset.
      do_read("A", 8'h50, 8'h00, 8'h00, 8'h00, 16'h0000, EXP_A_PTCH);

      // Raw rate 0x1050 from a fresh integrator.
      rst = 1'b1;
      tick();
      release_and_time("B boot");
      do_init("B");
      do_read("B", 8'h50, 8'h10, 8'h00, 8'h00, 16'h1000, EXP_B_PTCH);

      // 64 samples at zero compensated rate with AZ = 0x2000.
      rst = 1'b1;
      tick();
      release_and_time("C boot");
      do_init("C");
      for (int k = 1; k <= 64; k++) begin
         do_read("C", 8'h50, 8'h00, 8'h00, 8'h20, 16'h0000,
                 FUSION ? 16'(k / 2) : 16'h0000);
      end
      check("C final ptch", ptch, FUSION ? 16'd32 : 16'd0);

      // Reset in the middle of the AZL read, followed by a stray done.
      INT = 1'b1;
      wait_wrt(20, n);
      INT = 1'b0;
      do_txn("D RTL", 16'hA200, 8'h50);
      do_txn("D RTH", 16'hA300, 8'h00);
      wait_wrt(50, n);
      check("D AZL cmd", cmd, 16'hAC00);
      rst = 1'b1;
      #1;
      check_zero("D async reset");
      tick();
      rst     = 1'b0;
      done    = 1'b1;
      rd_data = 16'h00FF;
      tick();
      done    = 1'b0;
      rd_data = 16'h0000;
      check_zero("D after stray done");
      wait_wrt(WAIT_CLKS + 20, n);
      check("D pwr wait clks", 16'(n + 1), 16'(WAIT_CLKS));
      do_init("D");
      do_read("D", 8'h50, 8'h00, 8'h00, 8'h00, 16'h0000, EXP_A_PTCH);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/inertial_ptch_src.md
# inertial_ptch_src

Producer side of the pitch interface consumed by the balance controller. The block drives the IMU over the team's SPI master handshake: it configures the IMU once after reset, then reads gyro pitch-rate and Z-accel on every IMU data-ready. It integrates the compensated rate into a pitch estimate, and presents `ptch`, `ptch_rt` and a one-cycle `vld` strobe.

## Interface
Parameters:
- `INIT_WAIT_W`, 16: width of the post-reset IMU power-up timer; the block waits 2^INIT_WAIT_W clocks.
- `PTCH_RT_OFFSET`, 16'h0050: gyro zero-rate offset, subtracted from the raw rate.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `INT`  in  1  IMU data-ready; asynchronous, level
- `done`  in  1  SPI master transaction-complete pulse
- `rd_data`  in  16  SPI read data; the returned byte is in [7:0]
- `wrt`  out  1  one-cycle SPI transaction start
- `cmd`  out  16  SPI command word; held stable from `wrt` until `done`
- `ptch_rt`  out  16  signed compensated pitch rate
- `ptch`  out  16  signed pitch estimate
- `vld`  out  1  one-cycle strobe: `ptch`/`ptch_rt` are new

## Operation
- `INT` passes through a 2-flop synchronizer before use.
- FSM states and transitions:
  - `PWR_WAIT`: timer runs; on terminal count go to `INIT1`.
  - `INIT1`/`INIT2`/`INIT3`: send cmd 16'h0D02, 16'h1160, 16'h1060 in turn; each state advances on `done`. `INIT3` goes to `WAIT_INT`.
  - `WAIT_INT`: idle until synchronized `INT`=1.
  - `RD_RTL`/`RD_RTH`/`RD_AZL`/`RD_AZH`: send cmd 16'hA200, 16'hA300, 16'hAC00, 16'hAD00 in turn, each advancing on `done`. `rd_data[7:0]` is latched into the matching byte holding register on that `done`.
  - `UPDATE`: one cycle, then back to `WAIT_INT`.
- SPI handshake:
  - `wrt` pulses exactly one cycle on entry to each transaction state.
  - No new `wrt` is issued until `done` is received.
  - `done` outside a pending transaction is ignored.
- `UPDATE` arithmetic:
  - `ptch_rt` = {RTH,RTL} − `PTCH_RT_OFFSET`, 16-bit wrap.
  - `ptch_int` is a 27-bit signed accumulator: `ptch_int` += −sext27(`ptch_rt`) + `fusion`.
  - `ptch` = `ptch_int`[26:11].
  - `ptch_acc` = (signed AZ × signed 10'd327)[25:13], sign-extended to 16 bits; AZ = {AZH,AZL}.
- `INT` that stays high or re-rises during a read sequence is not queued. It is sampled again only in `WAIT_INT`.
- Holding registers are not cleared between samples.

## Timing
- Reset values: `wrt`=0, `cmd`=0, `ptch`=0, `ptch_rt`=0, `vld`=0, `ptch_int`=0, all byte registers=0, state=`PWR_WAIT`, timer=0.
- First `wrt` occurs 2^INIT_WAIT_W clocks after `rst` deasserts.
- Synchronized `INT` high to `wrt` for RD_RTL: 1 clock.
- `done` of `RD_AZH` → `UPDATE` next cycle. `ptch`, `ptch_rt` and `vld`=1 are all registered at the end of `UPDATE`, so `vld` is high in the cycle after `UPDATE`. Outputs then hold until the next `UPDATE`.
- `vld` is never high for two consecutive cycles.
- `rst` mid-transaction: immediate return to reset values. A later stray `done` is ignored; the SPI master is assumed to be reset by the same `rst`.
- `ptch_int` wraps on overflow; the range is sized so that overflow does not occur in use.

## Configuration
- `PTCH_ACC_FUSION_EN` defined: `fusion` = +1024 if `ptch_acc` > `ptch` (signed compare), else −1024. The AZ reads are performed and used.
- Undefined: `fusion` = 0. RD_AZL/RD_AZH are still performed, so the SPI sequence is identical, but AZ is unused (pure gyro integration).

## Test plan
- Reset, no SPI model activity → all outputs 0; exactly one `wrt` with cmd 16'h0D02 after 2^INIT_WAIT_W clocks.
- Init sequence, `done` returned 3 cycles after each `wrt` → commands 0D02, 1160, 1060 in order; no further `wrt` while `INT`=0.
- `INT`=1; reads return RTL=50, RTH=00, AZ=0, fusion off → `vld` pulse; `ptch_rt`=0, `ptch`=0.
- Same sequence with RTH=10 (raw 16'h1050) → `ptch_rt`=16'h1000, `ptch`=16'hFFFE. With fusion on → `ptch`=16'hFFFD.
- Fusion on; rate = offset, AZ=16'h2000 (`ptch_acc`=327) → after 64 samples `ptch`=32.
- `rst` asserted during RD_AZL, then a late `done` → outputs 0, no `wrt`; after release the full init repeats.
